uart_tx_fifo: RTL and testbench

Transmit buffer between the Z80 IO-port write decode and the UART transmitter core. Accepts one-cycle byte-write strobes from the IO decode, stores up to DEPTH bytes, and drains them one at a time into the core using its `data_in` / `data_in_wr` / `busy_tx` handshake. The CPU can then burst-write without polling busy per byte: software polls `full` (IO address 10, bit 0) instead of `busy_tx`.

---
 rtl/uart_tx_fifo.sv | 125 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_fifo : byte FIFO between the IO-port write decode and the UART   |
// |                transmitter core, drained through data_in_wr / busy_tx.   |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module uart_tx_fifo #(
   parameter int DEPTH       = 16,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             wr_data,
   input  logic                   wr_en,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   input  logic                   clr_overflow,
   output logic [7:0]             tx_data,
   output logic                   tx_wr,
   input  logic                   busy_tx
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_LW = c_AW + 1;
   localparam int c_CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(ACK_TIMEOUT - 1);
   localparam logic [c_LW-1:0] c_LVL_FULL = c_LW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_BUSY = 2'd1,
      ST_WAIT_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [7:0]        r_mem [DEPTH];
   logic [c_AW-1:0]   r_wr_ptr;
   logic [c_AW-1:0]   r_rd_ptr;
   logic [c_LW-1:0]   r_level;
   logic [c_CW-1:0]   r_cnt;
   logic              r_overflow;
   logic [7:0]        r_tx_data;
   logic              r_tx_wr;
   logic              w_push;
   logic              w_drop;
   logic              w_pop;

   assign full     = (r_level == c_LVL_FULL);
   assign empty    = (r_level == '0);
   assign level    = r_level;
   assign overflow = r_overflow;
   assign tx_data  = r_tx_data;
   assign tx_wr    = r_tx_wr;

   // Fullness is judged on the pre-edge level, so a same-cycle pop never rescues a write.
   assign w_push = wr_en & ~full;
   assign w_drop = wr_en & full;
   assign w_pop  = (r_state == ST_IDLE) & ~empty & ~busy_tx;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_pop) w_state_nxt = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (busy_tx)                  w_state_nxt = ST_WAIT_DONE;
            else if (r_cnt == c_CNT_LAST) w_state_nxt = ST_IDLE;
         end
         ST_WAIT_DONE: begin
            if (!busy_tx) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_cnt      <= '0;
         r_overflow <= 1'b0;
         r_tx_data  <= 8'h00;
         r_tx_wr    <= 1'b0;
      end else begin
         r_tx_wr <= w_pop;
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_tx_data <= r_mem[r_rd_ptr];
            r_cnt     <= '0;
         end else if (r_state == ST_WAIT_BUSY) begin
            r_cnt <= r_cnt + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         // A drop in the same cycle as a clear leaves the flag set.
         if (w_drop)            r_overflow <= 1'b1;
         else if (clr_overflow) r_overflow <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_fifo : directed bench for uart_tx_fifo with a simple core      |
// |                   busy model and a tx_wr monitor.                         |
// | Revision        : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       full;
   logic       empty;
   logic [4:0] level;
   logic       overflow;
   logic       clr_overflow;
   logic [7:0] tx_data;
   logic       tx_wr;
   logic       busy_tx;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         consec = 0;
   logic       prev_wr = 1'b0;
   logic       core_en = 1'b0;
   logic       busy_force = 1'b0;
   int         busy_cnt = 0;
   logic [7:0] tx_q [$];
   int         tx_t [$];
   int         max_level;

   uart_tx_fifo #(.DEPTH(16), .ACK_TIMEOUT(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_data      (wr_data),
      .wr_en        (wr_en),
      .full         (full),
      .empty        (empty),
      .level        (level),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .tx_data      (tx_data),
      .tx_wr        (tx_wr),
      .busy_tx      (busy_tx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Core model: busy for 10 cycles starting the cycle after a tx_wr strobe.
   always @(negedge clk) begin
      if (core_en) begin
         if (tx_wr)             busy_cnt = 10;
         else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
         busy_tx = (busy_cnt != 0);
      end else begin
         busy_cnt = 0;
         busy_tx  = busy_force;
      end
   end

   always @(negedge clk) begin
      if (tx_wr) begin
         tx_q.push_back(tx_data);
         tx_t.push_back(cyc);
         if (prev_wr) consec++;
      end
      prev_wr = tx_wr;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pulses(input int n, input int budget, input string tag);
      int k = 0;
      while (tx_q.size() < n && k < budget) begin
         step();
         k++;
      end
      check(tag, tx_q.size(), n);
   endtask

   task automatic push_byte(input logic [7:0] d);
      wr_data = d;
      wr_en   = 1'b1;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic clear_log();
      tx_q.delete();
      tx_t.delete();
   endtask

   initial begin
      reset        = 1'b0;
      wr_data      = 8'h00;
      wr_en        = 1'b0;
      clr_overflow = 1'b0;
      busy_tx      = 1'b0;
      repeat (3) step();
      check("rst_level", level, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_tx_wr", tx_wr, 0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_overflow", overflow, 0);
      reset = 1'b1;
      step();

      // Single byte with a 10-cycle busy core
      core_en = 1'b1;
      step();
      clear_log();
      wr_data = 8'h41;
      wr_en   = 1'b1;
      step();
      wr_en   = 1'b0;
      check("single_empty_after_write", empty, 0);
      check("single_level_after_write", level, 1);
      check("single_no_early_strobe", tx_wr, 0);
      step();
      check("single_strobe", tx_wr, 1);
      check("single_data", tx_data, 8'h41);
      check("single_empty_after_pop", empty, 1);
      step();
      check("single_strobe_one_cycle", tx_wr, 0);
      check("single_busy_seen", busy_tx, 1);
      push_byte(8'h42);
      wait_pulses(2, 40, "single_second_pulse");
      if (tx_q.size() >= 2) begin
         check("single_spacing", tx_t[1] - tx_t[0], 12);
         check("single_second_data", tx_q[1], 8'h42);
      end
      repeat (20) step();

      // Burst of 16 with drain held off until full
      core_en    = 1'b0;
      busy_force = 1'b1;
      step();
      step();
      clear_log();
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      check("burst_full", full, 1);
      check("burst_level", level, 16);
      check("burst_no_pop_yet", tx_q.size(), 0);
      core_en = 1'b1;
      wait_pulses(16, 400, "burst_pulses");
      repeat (30) step();
      check("burst_pulse_total", tx_q.size(), 16);
      for (int i = 0; i < 16 && i < tx_q.size(); i++) check("burst_order", tx_q[i], 32'(i));
      check("burst_empty", empty, 1);

      // Overflow: dropped write coinciding with a pop
      core_en    = 1'b0;
      busy_force = 1'b1;
      step();
      step();
      clear_log();
      for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
      check("ovf_full", full, 1);
      busy_force = 1'b0;
      wr_data    = 8'hAA;
      wr_en      = 1'b1;
      step();
      wr_en      = 1'b0;
      busy_force = 1'b1;
      check("ovf_set", overflow, 1);
      check("ovf_level", level, 15);
      check("ovf_pop_strobe", tx_wr, 1);
      check("ovf_pop_data", tx_data, 8'h80);
      push_byte(8'h90);
      check("ovf_refull", full, 1);
      wr_data      = 8'hBB;
      wr_en        = 1'b1;
      clr_overflow = 1'b1;
      step();
      wr_en        = 1'b0;
      check("ovf_set_beats_clear", overflow, 1);
      check("ovf_level_held", level, 16);
      step();
      clr_overflow = 1'b0;
      check("ovf_cleared", overflow, 0);
      busy_force = 1'b0;
      wait_pulses(17, 200, "ovf_drain_pulses");
      repeat (10) step();
      check("ovf_drain_total", tx_q.size(), 17);
      for (int i = 0; i < 17 && i < tx_q.size(); i++)
         check("ovf_drain_order", tx_q[i], 32'h80 + 32'(i));

      // Timeout pacing with busy_tx held low
      clear_log();
      push_byte(8'hC1);
      push_byte(8'hC2);
      push_byte(8'hC3);
      wait_pulses(3, 50, "to_pulses");
      repeat (12) step();
      check("to_pulse_total", tx_q.size(), 3);
      if (tx_q.size() >= 3) begin
         check("to_gap1", tx_t[1] - tx_t[0], 5);
         check("to_gap2", tx_t[2] - tx_t[1], 5);
         check("to_data0", tx_q[0], 8'hC1);
         check("to_data2", tx_q[2], 8'hC3);
      end
      check("to_empty", empty, 1);

      // Wrap-around: 40 write/drain pairs
      clear_log();
      max_level = 0;
      for (int i = 0; i < 40; i++) begin
         push_byte(8'h30 + 8'(i));
         if (int'(level) > max_level) max_level = int'(level);
         repeat (5) begin
            step();
            if (int'(level) > max_level) max_level = int'(level);
         end
      end
      wait_pulses(40, 50, "wrap_pulses");
      check("wrap_level_bound", (max_level <= 3), 1);
      for (int i = 0; i < 40 && i < tx_q.size(); i++)
         check("wrap_order", tx_q[i], 32'h30 + 32'(i));

      // Reset asserted mid-WAIT_DONE with 5 bytes buffered
      core_en = 1'b1;
      repeat (3) step();
      for (int i = 0; i < 6; i++) push_byte(8'h60 + 8'(i));
      check("rst2_level_before", level, 5);
      check("rst2_core_busy", busy_tx, 1);
      reset = 1'b0;
      #1;
      check("rst2_level", level, 0);
      check("rst2_empty", empty, 1);
      check("rst2_tx_wr", tx_wr, 0);
      check("rst2_tx_data", tx_data, 8'h00);
      step();
      reset = 1'b1;
      clear_log();
      repeat (30) step();
      check("rst2_no_strobe", tx_q.size(), 0);
      push_byte(8'h55);
      wait_pulses(1, 20, "rst2_new_pulse");
      if (tx_q.size() >= 1) check("rst2_new_data", tx_q[0], 8'h55);
      check("no_back_to_back_strobes", consec, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
